// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd on clk and delivers left/right sample pairs over valid/ready.
// Define I2S_RX_SYNC_EN to put a 2-flop synchronizer on each external line (default: single capture flop).
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             sck_s, ws_s, sd_s, sck_d;
  logic             bit_evt;
  logic             ws_prev, synced;
  logic [WIDTH-1:0] shreg, shreg_nx, word_nx;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] word, left_hold;
  logic             word_ch, word_stb, left_ok;

`ifdef I2S_RX_SYNC_EN
  logic [2:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta                 <= '0;
      {sck_s, ws_s, sd_s}  <= '0;
    end else begin
      meta                 <= {sck, ws, sd};
      {sck_s, ws_s, sd_s}  <= meta;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sck_s, ws_s, sd_s} <= '0;
    end else begin
      {sck_s, ws_s, sd_s} <= {sck, ws, sd};
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sck_d <= 1'b0;
    else       sck_d <= sck_s;
  end

  assign bit_evt = sck_s & ~sck_d;

  // Bits past WIDTH are dropped; a short word is left-justified with zero fill.
  always_comb begin
    shreg_nx = shreg;
    count_nx = count;
    if (count < CW'(WIDTH)) begin
      shreg_nx = {shreg[WIDTH-2:0], sd_s};
      count_nx = count + 1'b1;
    end
    word_nx = shreg_nx << (CW'(WIDTH) - count_nx);
  end

  // Stage 1: deserialize and detect word boundaries; the first boundary only aligns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      count    <= '0;
      ws_prev  <= 1'b0;
      synced   <= 1'b0;
      word     <= '0;
      word_ch  <= 1'b0;
      word_stb <= 1'b0;
    end else begin
      word_stb <= 1'b0;
      if (bit_evt) begin
        ws_prev <= ws_s;
        if (ws_s != ws_prev) begin
          shreg    <= '0;
          count    <= '0;
          word     <= word_nx;
          word_ch  <= ws_prev;
          word_stb <= synced;
          synced   <= 1'b1;
        end else begin
          shreg <= shreg_nx;
          count <= count_nx;
        end
      end
    end
  end

  // Stage 2: pair left/right words and hand the frame off, dropping it if the slot is still occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_hold <= '0;
      left_ok   <= 1'b0;
      left      <= '0;
      right     <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      if (word_stb) begin
        if (!word_ch) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          left_ok <= 1'b0;
          if (!valid || ready) begin
            left  <= left_hold;
            right <= word;
            valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx (WIDTH=16): directed and random I2S frames against a slot-level model.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset, sck, ws, sd, ready;
  logic [15:0] left, right;
  logic        valid, overrun;

  int n_assert = 0;
  int n_fail   = 0;
  bit model_synced = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

`ifdef I2S_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  i2s_rx #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .sck(sck), .ws(ws), .sd(sd),
    .left(left), .right(right), .valid(valid), .ready(ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && valid && ready) got_q.push_back({left, right});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: an n-bit slot lands in a 16-bit sample by truncating LSBs or zero-filling below.
  function automatic logic [15:0] fit(input logic [31:0] v, input int n);
    logic [31:0] t;
    if (n >= 16) t = v >> (n - 16);
    else         t = v << (16 - n);
    return t[15:0];
  endfunction

  function automatic logic [31:0] mask(input logic [31:0] v, input int n);
    logic [31:0] one;
    one = 32'd1;
    return v & ((one << n) - 32'd1);
  endfunction

  task automatic expect_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    exp_q.push_back({fit(l, n), fit(r, n)});
  endtask

  task automatic send_bit(input logic w, input logic d);
    @(posedge clk); #1;
    sck = 1'b0; ws = w; sd = d;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // WS flips one bit before the MSB of the next channel, so the LSB rides on the other channel's WS.
  task automatic send_word(input logic [31:0] v, input int n, input logic ch);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, v[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit track);
    send_word(l, n, 1'b0);
    send_word(r, n, 1'b1);
    if (track && model_synced) expect_frame(l, r, n);
    model_synced = 1'b1;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_check(input string tag);
    logic [31:0] g, e;
    check({tag, " count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " left"},  {16'h0, g[31:16]}, {16'h0, e[31:16]});
      check({tag, " right"}, {16'h0, g[15:0]},  {16'h0, e[15:0]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] l, r, r2;
    int n;

    reset = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset left", {16'h0, left}, 32'h0);
    check("reset right", {16'h0, right}, 32'h0);
    check("reset valid", {31'h0, valid}, 32'h0);
    check("reset overrun", {31'h0, overrun}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    for (int k = 0; k < 3; k++) send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    drain();
    drain_check("basic");
    check("basic overrun", {31'h0, overrun}, 32'h0);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(24, 4);
      l = mask($urandom, n);
      r = mask($urandom, n);
      send_frame(l, r, n, 1'b1);
    end
    drain();
    drain_check("random");

    send_frame(32'h8001FF, 32'h7FFE00, 24, 1'b1);
    send_frame(32'hABC, 32'h5A5, 12, 1'b1);
    drain();
    drain_check("width");

    // Hold one frame, then accept it in exactly the cycle the next one loads.
    @(posedge clk); #1 ready = 1'b0;
    l = mask($urandom, 16); r = mask($urandom, 16);
    send_frame(l, r, 16, 1'b0);
    drain();
    check("held valid", {31'h0, valid}, 32'h1);
    check("held left", {16'h0, left}, l);
    expect_frame(l, r, 16);
    l = mask($urandom, 16); r2 = mask($urandom, 16);
    send_word(l, 16, 1'b0);
    for (int i = 15; i >= 1; i--) send_bit(1'b1, r2[i]);
    @(posedge clk); #1;
    sck = 1'b0; ws = 1'b0; sd = r2[0];
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    repeat (LAT) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    check("same-cycle valid", {31'h0, valid}, 32'h1);
    check("same-cycle left", {16'h0, left}, l);
    check("same-cycle right", {16'h0, right}, r2);
    check("same-cycle overrun", {31'h0, overrun}, 32'h0);
    expect_frame(l, r2, 16);
    @(posedge clk); #1 ready = 1'b1;
    drain();
    drain_check("same-cycle");

    @(posedge clk); #1 ready = 1'b0;
    l = mask($urandom, 16); r = mask($urandom, 16);
    send_frame(l, r, 16, 1'b0);
    send_frame(mask($urandom, 16), mask($urandom, 16), 16, 1'b0);
    drain();
    check("overrun valid", {31'h0, valid}, 32'h1);
    check("overrun left", {16'h0, left}, l);
    check("overrun right", {16'h0, right}, r);
    check("overrun flag", {31'h0, overrun}, 32'h1);
    expect_frame(l, r, 16);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release valid", {31'h0, valid}, 32'h0);
    check("release overrun", {31'h0, overrun}, 32'h1);
    drain();
    drain_check("overrun");

    for (int i = 15; i >= 11; i--) send_bit(1'b0, i[0]);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("midreset left", {16'h0, left}, 32'h0);
    check("midreset right", {16'h0, right}, 32'h0);
    check("midreset valid", {31'h0, valid}, 32'h0);
    check("midreset overrun", {31'h0, overrun}, 32'h0);
    sck = 1'b0; ws = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_synced = 1'b0;
    send_frame(mask($urandom, 16), mask($urandom, 16), 16, 1'b1);
    send_frame(32'hBEEF, 32'h0F0F, 16, 1'b1);
    drain();
    drain_check("resync");
    check("final overrun", {31'h0, overrun}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
